// File: rtl/reg_8bit.sv
// Parallel-load register with true and complemented outputs.
// Synchronous clear has priority over synchronous preset.
module reg_8bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    input  logic             pr,
    input  logic             clr,
    input  logic             clk
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = d;
        if (pr) begin
            q_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // nq has no state of its own; it tracks q through clear and preset
    assign q  = q_q;
    assign nq = ~q_q;

endmodule

// File: tb/tb_reg_8bit.sv
// Directed self-checking bench for reg_8bit.
// Each task drives one scenario and checks q and nq inline.
module tb_reg_8bit;

    logic       clk;
    logic       clr;
    logic       pr;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] nq;

    int total;
    int bad;

    reg_8bit #(.WIDTH(8)) dut (
        .d  (d),
        .q  (q),
        .nq (nq),
        .pr (pr),
        .clr(clr),
        .clk(clk)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic test_load();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h55;
        exp_q[1] = 8'hAA;
        exp_q[2] = 8'h00;
        #11;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                #16 d = 8'hAA;
                #4;
            end
            if (i == 2) begin
                #4 d = 8'h00;
                #16;
            end
            total++;
            if (q !== exp_q[i]) begin
                bad++;
                $display("FAIL load_q%0d q=%h exp=%h", i, q, exp_q[i]);
            end
            total++;
            if (nq !== ~exp_q[i]) begin
                bad++;
                $display("FAIL load_nq%0d nq=%h exp=%h", i, nq, ~exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        d = 8'h55;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h55) begin
            bad++;
            $display("FAIL glitch_pre q=%h exp=55", q);
        end
        #1 d = 8'h0F;
        #3 d = 8'hF0;
        #10 d = 8'h3C;
        #4;
        total++;
        if (q !== 8'h55) begin
            bad++;
            $display("FAIL glitch_hold q=%h exp=55", q);
        end
        total++;
        if (nq !== 8'hAA) begin
            bad++;
            $display("FAIL glitch_hold_nq nq=%h exp=aa", nq);
        end
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h3C) begin
            bad++;
            $display("FAIL glitch_cap q=%h exp=3c", q);
        end
    endtask

    task automatic test_reset();
        d = 8'hAA;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'hAA) begin
            bad++;
            $display("FAIL clr_setup q=%h exp=aa", q);
        end
        d = 8'h77;
        clr = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h00 || nq !== 8'hFF) begin
            bad++;
            $display("FAIL clr_apply q=%h nq=%h exp=00/ff", q, nq);
        end
        clr = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h77 || nq !== 8'h88) begin
            bad++;
            $display("FAIL clr_release q=%h nq=%h exp=77/88", q, nq);
        end
    endtask

    task automatic test_preset();
        pr = 1'b1;
        d = 8'h12;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'hFF || nq !== 8'h00) begin
            bad++;
            $display("FAIL pr_apply q=%h nq=%h exp=ff/00", q, nq);
        end
        pr = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h12 || nq !== 8'hED) begin
            bad++;
            $display("FAIL pr_release q=%h nq=%h exp=12/ed", q, nq);
        end
    endtask

    task automatic test_conflict();
        pr = 1'b1;
        clr = 1'b1;
        d = 8'hC3;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h00 || nq !== 8'hFF) begin
            bad++;
            $display("FAIL conflict q=%h nq=%h exp=00/ff", q, nq);
        end
        pr = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'hC3 || nq !== 8'h3C) begin
            bad++;
            $display("FAIL conflict_rel q=%h nq=%h exp=c3/3c", q, nq);
        end
    endtask

    task automatic test_async_clear();
        d = 8'h55;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h55) begin
            bad++;
            $display("FAIL async_setup q=%h exp=55", q);
        end
        #4 clr = 1'b1;
        #4;
        total++;
        if (q !== 8'h55 || nq !== 8'hAA) begin
            bad++;
            $display("FAIL async_hold q=%h nq=%h exp=55/aa", q, nq);
        end
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h00 || nq !== 8'hFF) begin
            bad++;
            $display("FAIL async_clr q=%h nq=%h exp=00/ff", q, nq);
        end
        clr = 1'b0;
        d = 8'h96;
        @(posedge clk);
        #1;
        total++;
        if (q !== 8'h96 || nq !== 8'h69) begin
            bad++;
            $display("FAIL async_rel q=%h nq=%h exp=96/69", q, nq);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [6];
        logic [7:0] inv [6];
        vec[0] = 8'h01; inv[0] = 8'hFE;
        vec[1] = 8'h80; inv[1] = 8'h7F;
        vec[2] = 8'hFE; inv[2] = 8'h01;
        vec[3] = 8'h7F; inv[3] = 8'h80;
        vec[4] = 8'hA5; inv[4] = 8'h5A;
        vec[5] = 8'h5A; inv[5] = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            d = vec[i];
            @(posedge clk);
            #1;
            total++;
            if (q !== vec[i] || nq !== inv[i]) begin
                bad++;
                $display("FAIL b2b_%0d q=%h nq=%h exp=%h/%h",
                         i, q, nq, vec[i], inv[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        d = 8'h55;
        pr = 1'b0;
        clr = 1'b0;
        test_load();
        test_glitch();
        test_reset();
        test_preset();
        test_conflict();
        test_async_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
